mux_rr_arbiter: RTL

Round-robin arbiter and output register for the 16-way 32-bit select datapath. It shares one output channel among NUM_REQ requesters. Each cycle it picks one pending requester, loads that requester's word into a registered output stage, and presents the word to the consumer on a valid/ready handshake. It sits between the requester ports and the downstream consumer, and replaces free-running select control with fair, back-pressure-aware sequencing.

---
 rtl/mux_arb_pkg.sv | 8 +
 rtl/mux_rr_arbiter_rr_pick.sv | 22 ++
 rtl/mux_rr_arbiter.sv | 66 ++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, source index type and state enum for mux_rr_arbiter
package mux_arb_pkg;
  localparam int NUM_REQ = 16;
  localparam int DATA_W = 32;
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, searching upward from ptr+1 with wrap
module rr_pick #(
  parameter int NUM_REQ = mux_arb_pkg::NUM_REQ,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win,
  output logic               any
);
  logic [IDX_W-1:0] idx;
  // Walk from farthest offset to nearest so the closest pending index wins last.
  always_comb begin
    win = '0;
    idx = '0;
    any = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) win = idx;
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter feeding a registered valid/ready output stage.
// Optional burst lock enabled by defining MUX_ARB_LOCK_EN.
module mux_rr_arbiter #(
  parameter int DATA_W = mux_arb_pkg::DATA_W,
  parameter int NUM_REQ = mux_arb_pkg::NUM_REQ,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]             lock,
`endif
  output logic [NUM_REQ-1:0]             ack,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [IDX_W-1:0]               out_src
);
  import mux_arb_pkg::*;
  state_t state;
  logic [IDX_W-1:0] ptr, win, sel;
  logic any, drain, load;
  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req(req),
    .ptr(ptr),
    .win(win),
    .any(any)
  );
`ifdef MUX_ARB_LOCK_EN
  logic locked;
  logic [IDX_W-1:0] lock_idx;
  // A live lock overrides round-robin; ptr already equals lock_idx so it stays put.
  assign sel = (locked && req[lock_idx]) ? lock_idx : win;
`else
  assign sel = win;
`endif
  assign out_valid = (state == FULL);
  assign drain = out_valid && out_ready;
  assign load = (!out_valid || drain) && any;
  assign ack = (load && !rst) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      out_data <= '0;
      out_src <= '0;
      ptr <= '1;
`ifdef MUX_ARB_LOCK_EN
      locked <= 1'b0;
      lock_idx <= '0;
`endif
    end else if (load) begin
      state <= FULL;
      out_data <= data[sel];
      out_src <= sel;
      ptr <= sel;
`ifdef MUX_ARB_LOCK_EN
      locked <= lock[sel];
      lock_idx <= sel;
`endif
    end else if (drain) begin
      state <= EMPTY;
    end
  end
endmodule
